multi_issue_buffer: RTL

- Parametrised, in-order, multi-lane issue buffer between rename and the scoreboard.
- Generalises the single-instruction decoded/issue handshake of the issue stage to NR_ENQ enqueue lanes and NR_ISS issue lanes.
- Adds intra-group RAW hazard blocking, so lane k never issues alongside an older lane that writes one of its sources.
- Stores instructions as opaque payload plus register fields; it does no operand reading.

---
 rtl/multi_issue_buffer_pkg.sv | 24 ++
 rtl/multi_issue_buffer_iq_hazard_check.sv | 22 ++
 rtl/multi_issue_buffer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/multi_issue_buffer_pkg.sv
// Shared types and helpers for the multi-lane in-order issue buffer.
package multi_issue_buffer_pkg;

    localparam int unsigned IQ_DEPTH     = 8;
    localparam int unsigned IQ_PAYLOAD_W = 64;
    localparam int unsigned IQ_REG_W     = 5;
    localparam int unsigned CNT_W        = $clog2(IQ_DEPTH + 1);
    localparam int unsigned PTR_W        = $clog2(IQ_DEPTH);

    typedef struct packed {
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic [IQ_REG_W-1:0]     rd;
        logic [IQ_REG_W-1:0]     rs1;
        logic [IQ_REG_W-1:0]     rs2;
        logic                    we;
    } iq_lane_t;

    // Younger instruction reads a register the older one writes (x0 never conflicts).
    function automatic logic raw_hazard(input iq_lane_t older, input iq_lane_t younger);
        return older.we && (older.rd != '0) &&
               ((older.rd == younger.rs1) || (older.rd == younger.rs2));
    endfunction

endpackage

// File: rtl/multi_issue_buffer_iq_hazard_check.sv
// Flags issue lanes that read a register written by any older lane in the same group.
module iq_hazard_check
    import multi_issue_buffer_pkg::*;
#(
    parameter int unsigned NR_ISS = 2
) (
    input  iq_lane_t [NR_ISS-1:0] cand,
    output logic     [NR_ISS-1:0] blocked
);

    always_comb begin
        blocked = '0;
        for (int k = 1; k < NR_ISS; k++) begin
            for (int j = 0; j < k; j++) begin
                if (raw_hazard(cand[j], cand[k])) begin
                    blocked[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_issue_buffer.sv
// In-order circular issue buffer: NR_ENQ lanes in, NR_ISS lanes out, with
// intra-group RAW blocking. Enqueued entries become visible the next cycle.
module multi_issue_buffer
    import multi_issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = IQ_DEPTH,
    parameter int unsigned NR_ENQ    = 2,
    parameter int unsigned NR_ISS    = 2,
    parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W,
    parameter int unsigned REG_W     = IQ_REG_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          stall_i,
    input  logic [NR_ENQ-1:0]             enq_valid_i,
    input  logic [NR_ENQ*PAYLOAD_W-1:0]   enq_data_i,
    input  logic [NR_ENQ*REG_W-1:0]       enq_rd_i,
    input  logic [NR_ENQ*REG_W-1:0]       enq_rs1_i,
    input  logic [NR_ENQ*REG_W-1:0]       enq_rs2_i,
    input  logic [NR_ENQ-1:0]             enq_we_i,
    output logic [NR_ENQ-1:0]             enq_ready_o,
    output logic [NR_ISS-1:0]             iss_valid_o,
    output logic [NR_ISS*PAYLOAD_W-1:0]   iss_data_o,
    output logic [NR_ISS*REG_W-1:0]       iss_rd_o,
    output logic [NR_ISS*REG_W-1:0]       iss_rs1_o,
    output logic [NR_ISS*REG_W-1:0]       iss_rs2_o,
    output logic [NR_ISS-1:0]             iss_we_o,
    input  logic [NR_ISS-1:0]             iss_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy_o,
    output logic                          issue_stall_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    iq_lane_t               mem_q [DEPTH];
    logic [IDX_W-1:0]       head_q;
    logic [IDX_W-1:0]       tail_q;
    logic [OCC_W-1:0]       count_q;

    logic [OCC_W-1:0]       free;
    logic [OCC_W-1:0]       enq_cnt;
    logic [OCC_W-1:0]       iss_cnt;
    logic [NR_ENQ-1:0]      enq_fire;
    logic [IDX_W-1:0]       wr_idx [NR_ENQ];
    iq_lane_t [NR_ENQ-1:0]  enq_lane;
    iq_lane_t [NR_ISS-1:0]  cand;
    logic [NR_ISS-1:0]      cand_ok;
    logic [NR_ISS-1:0]      blocked;
    logic [NR_ISS-1:0]      iss_valid;

    // Explicit modulo-DEPTH add; offsets never exceed DEPTH so one subtraction suffices.
    function automatic logic [IDX_W-1:0] ptr_add(input logic [IDX_W-1:0] p,
                                                 input logic [OCC_W-1:0] off);
        logic [OCC_W:0] s;
        s = (OCC_W+1)'(p) + (OCC_W+1)'(off);
        if (s >= (OCC_W+1)'(DEPTH)) begin
            s = s - (OCC_W+1)'(DEPTH);
        end
        return IDX_W'(s);
    endfunction

    // Credits come from registered occupancy only; same-cycle dequeues give none.
    assign free = OCC_W'(DEPTH) - count_q;

    always_comb begin
        enq_ready_o = '0;
        for (int k = 0; k < NR_ENQ; k++) begin
            enq_ready_o[k] = !rst_i && (free > OCC_W'(k));
        end
    end

    assign enq_fire = enq_valid_i & enq_ready_o & {NR_ENQ{!flush_i}};

    always_comb begin
        for (int k = 0; k < NR_ENQ; k++) begin
            enq_lane[k].payload = IQ_PAYLOAD_W'(enq_data_i[k*PAYLOAD_W +: PAYLOAD_W]);
            enq_lane[k].rd      = IQ_REG_W'(enq_rd_i[k*REG_W +: REG_W]);
            enq_lane[k].rs1     = IQ_REG_W'(enq_rs1_i[k*REG_W +: REG_W]);
            enq_lane[k].rs2     = IQ_REG_W'(enq_rs2_i[k*REG_W +: REG_W]);
            enq_lane[k].we      = enq_we_i[k];
        end
    end

    // Accepted lanes are packed at tail in lane order.
    always_comb begin
        enq_cnt = '0;
        for (int k = 0; k < NR_ENQ; k++) begin
            wr_idx[k] = ptr_add(tail_q, enq_cnt);
            if (enq_fire[k]) begin
                enq_cnt = enq_cnt + OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NR_ENQ; k++) begin
            if (enq_fire[k]) begin
                mem_q[wr_idx[k]] <= enq_lane[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NR_ISS; k++) begin
            cand[k]    = mem_q[ptr_add(head_q, OCC_W'(k))];
            cand_ok[k] = OCC_W'(k) < count_q;
        end
    end

    iq_hazard_check #(
        .NR_ISS (NR_ISS)
    ) u_hazard (
        .cand    (cand),
        .blocked (blocked)
    );

    assign iss_valid = cand_ok & ~blocked & {NR_ISS{!stall_i && !flush_i && !rst_i}};

    // Only the accepted prefix is consumed; a ready lane behind a refused one stays.
    always_comb begin
        logic run;
        run     = 1'b1;
        iss_cnt = '0;
        for (int k = 0; k < NR_ISS; k++) begin
            run = run && iss_valid[k] && iss_ready_i[k];
            if (run) begin
                iss_cnt = iss_cnt + OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= ptr_add(head_q, iss_cnt);
            tail_q  <= ptr_add(tail_q, enq_cnt);
            count_q <= count_q + enq_cnt - iss_cnt;
        end
    end

    always_comb begin
        for (int k = 0; k < NR_ISS; k++) begin
            iss_data_o[k*PAYLOAD_W +: PAYLOAD_W] = PAYLOAD_W'(cand[k].payload);
            iss_rd_o[k*REG_W +: REG_W]           = REG_W'(cand[k].rd);
            iss_rs1_o[k*REG_W +: REG_W]          = REG_W'(cand[k].rs1);
            iss_rs2_o[k*REG_W +: REG_W]          = REG_W'(cand[k].rs2);
            iss_we_o[k]                          = cand[k].we;
        end
    end

    assign iss_valid_o   = iss_valid;
    assign occupancy_o   = count_q;
    assign issue_stall_o = !rst_i && (count_q != '0) && !(iss_valid[0] && iss_ready_i[0]);

    // Lane valids must be a prefix starting at lane 0.
    assert property (@(posedge clk_i) disable iff (rst_i)
        ((enq_valid_i & (enq_valid_i + NR_ENQ'(1))) == '0))
        else $error("multi_issue_buffer: non-prefix enq_valid_i %b", enq_valid_i);

endmodule
